// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 one-hot decoder: accepts a code over valid/ready and holds its one-hot for HOLD_CYCLES.
// Optional macro DEC_GAP_EN adds a one-cycle all-zero GAP after each pulse (break-before-make).
module decoder_3to8_seq #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  logic [7:0]      y_d;
  logic            busy_d;
  logic            done_d;

  // Next-state, counter and latched-code logic; in_ready depends only on registered state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = DRIVE;
          cnt_d   = RELOAD;
          code_d  = code;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
`ifdef DEC_GAP_EN
          state_d = GAP;
`else
          // Last hold cycle doubles as an accept slot so pulses can abut.
          in_ready = 1'b1;
          if (in_valid) begin
            cnt_d  = RELOAD;
            code_d = code;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    y_d    = (state_d == DRIVE) ? 8'(8'h01 << code_d) : 8'h00;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DRIVE) && (cnt_d == '0);
  end

  // State and registered outputs; reset abandons any pulse in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= 3'd0;
      Y       <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      Y       <= y_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: two instances (HOLD_CYCLES=4 and 1) share stimulus and are
// checked every cycle against a pulse-timeline model, plus directed literal checks.
module tb_decoder_3to8_seq;

`ifdef DEC_GAP_EN
  localparam int GAPC = 1;
`else
  localparam int GAPC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] code = 3'd0;
  logic [1:0] rdy;
  logic [1:0] bsy;
  logic [1:0] dn;
  logic [7:0] y [2];

  int n_checks = 0;
  int n_fail   = 0;

  decoder_3to8_seq #(.HOLD_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .code(code), .Y(y[0]), .busy(bsy[0]), .done(dn[0])
  );

  decoder_3to8_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .code(code), .Y(y[1]), .busy(bsy[1]), .done(dn[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Timeline model: each instance's current pulse occupies cycles [s_c, e_c].
  int         hold [2] = '{4, 1};
  int         s_c  [2] = '{-200, -200};
  int         e_c  [2] = '{-100, -100};
  logic [7:0] oh_m [2] = '{8'h00, 8'h00};
  int         cyc = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] ey;
      logic       er;
      if (!rst_n) begin
        chk("rst_y", i, 32'(y[i]), 32'h0);
        chk("rst_busy", i, 32'(bsy[i]), 32'h0);
        chk("rst_done", i, 32'(dn[i]), 32'h0);
        s_c[i] = -200;
        e_c[i] = -100;
      end else begin
        ey = (cyc >= s_c[i] && cyc <= e_c[i]) ? oh_m[i] : 8'h00;
        er = (cyc >= e_c[i] + 2 * GAPC);
        chk("model_y", i, 32'(y[i]), 32'(ey));
        chk("model_busy", i, 32'(bsy[i]), 32'(cyc >= s_c[i] && cyc <= e_c[i] + GAPC));
        chk("model_done", i, 32'(dn[i]), 32'(cyc == e_c[i]));
        chk("model_ready", i, 32'(rdy[i]), 32'(er));
        if (in_valid && er) begin
          s_c[i]  = cyc + 1;
          e_c[i]  = cyc + hold[i];
          oh_m[i] = 8'(8'h01 << code);
        end
      end
      chk("onehot", i, 32'($countones(y[i]) <= 1), 32'h1);
    end
    cyc++;
  end

  // Raise in_valid with code c and return just after the edge that accepts it on dut0.
  task automatic send(input logic [2:0] c);
    bit got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    code     = c;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (rdy[0]) got = 1'b1;
    end
    chk("send_accept", 0, 32'(got), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (!bsy[0] && !bsy[1] && rdy[0] && rdy[1]) ok = 1'b1;
    end
    chk("idle_reached", 0, 32'(ok), 32'h1);
  endtask

  initial begin
    logic [7:0] oh_tab [8];
    logic [7:0] seq [12];
    logic [7:0] ex;
    bit         drop;
    oh_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk("idle_y", 0, 32'(y[0]), 32'h0);
      chk("idle_busy", 0, 32'(bsy[0]), 32'h0);
      chk("idle_done", 0, 32'(dn[0]), 32'h0);
      chk("idle_ready", 0, 32'(rdy[0]), 32'h1);
    end

    // Single decode of code 5
    send(3'd5);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("single_y", 0, 32'(y[0]), 32'h20);
      chk("single_done", 0, 32'(dn[0]), 32'(k == 3));
    end
    @(negedge clk);
    chk("single_after_y", 0, 32'(y[0]), 32'h0);
    chk("single_after_busy", 0, 32'(bsy[0]), 32'(GAPC));
    wait_idle();

    // Exhaustive codes
    for (int c = 0; c < 8; c++) begin
      send(3'(c));
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("exh_y", 0, 32'(y[0]), 32'(oh_tab[c]));
      end
      wait_idle();
    end

    // Back-to-back 2 then 6 with in_valid held
    send(3'd2);
    code = 3'd6;
    drop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seq[i] = y[0];
      if (rdy[0]) drop = 1'b1;
      @(posedge clk); #1;
      if (drop) in_valid = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 4) ex = 8'h04;
      else if (i < 4 + 2 * GAPC) ex = 8'h00;
      else if (i < 8 + 2 * GAPC) ex = 8'h40;
      else ex = 8'h00;
      chk("b2b_seq", 0, 32'(seq[i]), 32'(ex));
    end
    wait_idle();

    // Code change mid-pulse is ignored
    send(3'd3);
    code = 3'd7;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midchg_y", 0, 32'(y[0]), 32'h08);
      chk("midchg_ready", 0, 32'(rdy[0]), 32'(k == 3 && GAPC == 0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset during cycle 2 of a code-1 pulse
    send(3'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("prerst_y", 0, 32'(y[0]), 32'h02);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", 0, 32'(y[0]), 32'h0);
    chk("async_rst_busy", 0, 32'(bsy[0]), 32'h0);
    chk("async_rst_done", 0, 32'(dn[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_resume_y", 0, 32'(y[0]), 32'h0);
      chk("no_resume_busy", 0, 32'(bsy[0]), 32'h0);
    end

    // HOLD_CYCLES=1 instance, code 4
    send(3'd4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("h1_y", 1, 32'(y[1]), 32'h10);
    chk("h1_done", 1, 32'(dn[1]), 32'h1);
    chk("h1_long_y", 0, 32'(y[0]), 32'h10);
    @(negedge clk);
    chk("h1_after_y", 1, 32'(y[1]), 32'h0);
    chk("h1_after_done", 1, 32'(dn[1]), 32'h0);
    wait_idle();

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      code     = 3'($urandom_range(0, 7));
      rst_n    = ($urandom_range(0, 99) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
